// File: rtl/div_5.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : div_5
//  Purpose  : Divide-by-5 clock generator with 50% duty output. Two modulo-5
//             counters, one on each Clk edge, each produce a 2-of-5 phase.
//             ORing the rising-edge phase with the half-period-late
//             falling-edge phase gives a 2.5-period-high, 2.5-period-low
//             clock.
//  Ports    : Clk      in   system clock (both edges used)
//             rst_n    in   asynchronous active-low reset
//             clk_div  out  Clk/5, 50% duty (clk_pose | clk_nege)
//             clk_pose out  rising-edge phase, high 2 of 5 periods
//             clk_nege out  falling-edge phase, clk_pose lagged half a period
//             coutpose out  rising-edge modulo-5 count
//             coutnege out  falling-edge modulo-5 count
//  Options  : DIV_5_RST_SYNC_EN - when defined, rst_n de-assertion is
//             synchronised by two flops in each edge domain; assertion
//             stays asynchronous.
//  Revision : 1.0  initial release
// ============================================================================
module div_5 (
   input  logic       Clk,
   input  logic       rst_n,
   output logic       clk_div,
   output logic       clk_pose,
   output logic       clk_nege,
   output logic [2:0] coutpose,
   output logic [2:0] coutnege
);

   localparam logic [2:0] C_CNT_LAST = 3'd4;
   localparam logic [2:0] C_CNT_ZERO = 3'd0;

   // Per-domain resets (active low)
   logic rst_pose_n;
   logic rst_nege_n;

`ifdef DIV_5_RST_SYNC_EN
   logic [1:0] sync_pose_q;
   logic [1:0] sync_nege_q;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_pose_q <= 2'b00;
      end else begin
         sync_pose_q <= {sync_pose_q[0], 1'b1};
      end
   end

   always_ff @(negedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_nege_q <= 2'b00;
      end else begin
         sync_nege_q <= {sync_nege_q[0], 1'b1};
      end
   end

   assign rst_pose_n = sync_pose_q[1];
   assign rst_nege_n = sync_nege_q[1];
`else
   assign rst_pose_n = rst_n;
   assign rst_nege_n = rst_n;
`endif

   // ------------------------------------------------------------------------
   // Rising-edge domain
   // ------------------------------------------------------------------------
   logic [2:0] coutpose_q;
   logic [2:0] coutpose_d;
   logic       clk_pose_q;
   logic       clk_pose_d;
   // Set by the first rising edge out of reset; lets the falling-edge domain
   // start counting only after the rising-edge domain has, which keeps the
   // two counters in lock-step regardless of where reset release falls.
   logic       run_q;

   always_comb begin
      coutpose_d = C_CNT_ZERO;
      clk_pose_d = 1'b0;
      // 4 wraps to 0; illegal 5..7 also recover to 0
      if (coutpose_q < C_CNT_LAST) begin
         coutpose_d = coutpose_q + 3'd1;
      end
      clk_pose_d = (coutpose_q == C_CNT_LAST) || (coutpose_q == C_CNT_ZERO);
   end

   always_ff @(posedge Clk or negedge rst_pose_n) begin
      if (!rst_pose_n) begin
         coutpose_q <= C_CNT_ZERO;
         clk_pose_q <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         coutpose_q <= coutpose_d;
         clk_pose_q <= clk_pose_d;
         run_q      <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Falling-edge domain
   // ------------------------------------------------------------------------
   logic [2:0] coutnege_q;
   logic [2:0] coutnege_d;
   logic       clk_nege_q;
   logic       clk_nege_d;

   always_comb begin
      coutnege_d = coutnege_q;
      clk_nege_d = clk_nege_q;
      if (run_q) begin
         coutnege_d = C_CNT_ZERO;
         if (coutnege_q < C_CNT_LAST) begin
            coutnege_d = coutnege_q + 3'd1;
         end
         clk_nege_d = (coutnege_q == C_CNT_LAST) || (coutnege_q == C_CNT_ZERO);
      end
   end

   always_ff @(negedge Clk or negedge rst_nege_n) begin
      if (!rst_nege_n) begin
         coutnege_q <= C_CNT_ZERO;
         clk_nege_q <= 1'b0;
      end else begin
         coutnege_q <= coutnege_d;
         clk_nege_q <= clk_nege_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign coutpose = coutpose_q;
   assign coutnege = coutnege_q;
   assign clk_pose = clk_pose_q;
   assign clk_nege = clk_nege_q;
   assign clk_div  = clk_pose_q | clk_nege_q;

endmodule
`default_nettype wire

// File: tb/tb_div_5.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_div_5
//  Purpose  : Directed self-checking bench for div_5 (20 ns Clk, first rising
//             edge at 10 ns, reset released at 35 ns).
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_5;

   logic       Clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_div;
   logic       clk_pose;
   logic       clk_nege;
   logic [2:0] coutpose;
   logic [2:0] coutnege;

   int total = 0;
   int bad   = 0;

   div_5 dut (
      .Clk      (Clk),
      .rst_n    (rst_n),
      .clk_div  (clk_div),
      .clk_pose (clk_pose),
      .clk_nege (clk_nege),
      .coutpose (coutpose),
      .coutnege (coutnege)
   );

   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic at(input longint t);
      if ($time < t) #(t - $time);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".coutpose"}, coutpose, 0);
      chk({tag, ".coutnege"}, coutnege, 0);
      chk({tag, ".clk_pose"}, clk_pose, 0);
      chk({tag, ".clk_nege"}, clk_nege, 0);
      chk({tag, ".clk_div"},  clk_div,  0);
   endtask

   initial begin
      logic [2:0] exp_cnt  [9];
      logic       exp_pose [9];
      logic       prev_pose;
      logic       prev_div;
      longint     r1;
      longint     f1;
      longint     r2;

      exp_cnt  = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      exp_pose = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      at(5);
      chk_zero("rst_t5");
      at(31);
      chk_zero("rst_t31");
      at(35);
      rst_n = 1'b1;

`ifdef DIV_5_RST_SYNC_EN
      at(51);
      chk("sync_t51.coutpose", coutpose, 0);
      at(71);
      chk("sync_t71.coutpose", coutpose, 0);
      at(81);
      chk("sync_t81.coutnege", coutnege, 0);
      at(91);
      chk("sync_t91.coutpose", coutpose, 1);
      chk("sync_t91.clk_pose", clk_pose, 1);
      at(101);
      chk("sync_t101.coutnege", coutnege, 1);
      chk("sync_t101.clk_nege", clk_nege, 1);
`else
      // Falling edge at 40 must not advance: falling domain waits for rising
      at(41);
      chk("t41.coutnege", coutnege, 0);
      chk("t41.clk_nege", clk_nege, 0);
      chk("t41.coutpose", coutpose, 0);
      at(51);
      chk("t51.coutpose", coutpose, 1);
      chk("t51.clk_pose", clk_pose, 1);
      chk("t51.clk_div",  clk_div,  1);
      chk("t51.coutnege", coutnege, 0);
      chk("t51.clk_nege", clk_nege, 0);
      at(61);
      chk("t61.coutnege", coutnege, 1);
      chk("t61.clk_nege", clk_nege, 1);
      chk("t61.clk_div",  clk_div,  1);

      // Steady sequence, rising edges 70..230 and falling edges 80..240
      prev_pose = 1'b1;
      for (int i = 0; i < 9; i++) begin
         at(71 + 20 * i);
         chk($sformatf("rise%0d.coutpose", i), coutpose, exp_cnt[i]);
         chk($sformatf("rise%0d.clk_pose", i), clk_pose, exp_pose[i]);
         chk($sformatf("rise%0d.clk_div", i),  clk_div,  exp_pose[i] | prev_pose);
         at(81 + 20 * i);
         chk($sformatf("fall%0d.coutnege", i), coutnege, exp_cnt[i]);
         chk($sformatf("fall%0d.clk_nege", i), clk_nege, exp_pose[i]);
         chk($sformatf("fall%0d.clk_div", i),  clk_div,  exp_pose[i]);
         prev_pose = exp_pose[i];
      end

      // Measure clk_div high/low time; odd sample times never hit an edge
      r1 = -1;
      f1 = -1;
      r2 = -1;
      prev_div = clk_div;
      for (int k = 0; k < 150 && r2 < 0; k++) begin
         #2;
         if (clk_div && !prev_div) begin
            if (r1 < 0) begin
               r1 = $time;
               chk("div_rise.coutpose", coutpose, 0);
            end else if (f1 >= 0) begin
               r2 = $time;
            end
         end
         if (!clk_div && prev_div && r1 >= 0 && f1 < 0) begin
            f1 = $time;
         end
         prev_div = clk_div;
      end
      chk("div_first_rise_time", r1, 331);
      chk("div_high_ns", f1 - r1, 50);
      chk("div_low_ns",  r2 - f1, 50);

      // Mid-period reset
      at(436);
      chk("pre_abort.clk_div", clk_div, 1);
      at(437);
      rst_n = 1'b0;
      at(438);
      chk_zero("abort_t438");
      at(451);
      chk_zero("abort_t451");
      at(452);
      rst_n = 1'b1;
      at(461);
      chk("t461.coutnege", coutnege, 0);
      chk("t461.coutpose", coutpose, 0);
      at(471);
      chk("t471.coutpose", coutpose, 1);
      chk("t471.clk_pose", clk_pose, 1);
      at(481);
      chk("t481.coutnege", coutnege, 1);
      chk("t481.clk_nege", clk_nege, 1);

      // Illegal count recovery
      at(491);
      chk("t491.coutpose", coutpose, 2);
      at(492);
      force dut.coutpose_q = 3'd6;
      at(493);
      release dut.coutpose_q;
      at(494);
      chk("forced.coutpose", coutpose, 6);
      at(511);
      chk("recover.coutpose", coutpose, 0);
      chk("recover.clk_pose", clk_pose, 0);
      at(531);
      chk("resume1.coutpose", coutpose, 1);
      chk("resume1.clk_pose", clk_pose, 1);
      at(551);
      chk("resume2.coutpose", coutpose, 2);
      chk("resume2.clk_pose", clk_pose, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_5.md
DIV_5 -- requirements
Module: div_5

Interface
REQ-001 The block SHALL have no parameters; the divide ratio is fixed at 5 and the counter width at 3 bits.
REQ-002 Clk  input  1  single system clock; all state is clocked by Clk (rising- and falling-edge domains).
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clk_div  output  1  divided clock, Clk/5, 50% duty (high 2.5 Clk periods, low 2.5).
REQ-005 clk_pose  output  1  rising-edge-domain phase, high 2 of every 5 Clk periods.
REQ-006 clk_nege  output  1  falling-edge-domain phase, high 2 of every 5 Clk periods, lagging clk_pose by half a Clk period.
REQ-007 coutpose  output  3  rising-edge modulo-5 counter value.
REQ-008 coutnege  output  3  falling-edge modulo-5 counter value.

Function
REQ-009 On every rising Clk edge out of reset, coutpose SHALL advance 0,1,2,3,4,0,... (4 wraps to 0; values 5-7 never occur).
REQ-010 If coutpose ever holds 5-7, the next rising edge SHALL load 0.
REQ-011 On every rising edge, clk_pose SHALL be registered high when the pre-edge coutpose is 4 or 0, and low otherwise; in steady state, clk_pose = 1 exactly while coutpose is 0 or 1.
REQ-012 On every falling Clk edge out of reset, coutnege SHALL advance 0..4 with the same wrap and illegal-value rules as coutpose.
REQ-013 On every falling edge, clk_nege SHALL be registered high when the pre-edge coutnege is 4 or 0, and low otherwise.
REQ-014 clk_div SHALL be the combinational OR of clk_pose and clk_nege, with no further registering.
REQ-015 In steady state, clk_div SHALL rise 0 ns after the rising edge that takes coutpose to 0 and fall half a period after the rising edge that takes coutpose to 2.
REQ-016 The period of clk_div SHALL be exactly 5 Clk periods.
REQ-017 The first clk_div period after reset SHALL be irregular: clk_pose is high for 1 period only, as a consequence of REQ-011. All later periods SHALL conform to REQ-004.
REQ-018 The two counters SHALL stay in lock-step, so that coutnege equals coutpose between a falling edge and the next rising edge.

Reset
REQ-019 rst_n low SHALL immediately force coutpose = 0, coutnege = 0, clk_pose = 0, clk_nege = 0 and clk_div = 0, independent of Clk.
REQ-020 An assertion of rst_n mid-period SHALL abort the current output period with no glitch beyond the forced low.
REQ-021 Counting SHALL resume from 0 on the first rising edge, and the first falling edge, after rst_n is released.

Configuration
REQ-022 With DIV_5_RST_SYNC_EN defined, rst_n SHALL pass through a 2-flop synchronizer: assertion stays asynchronous, and de-assertion is synchronized separately into the rising-edge domain (two rising edges) and the falling-edge domain (two falling edges).
REQ-023 With DIV_5_RST_SYNC_EN defined, the first coutpose increment SHALL occur on the 3rd rising edge after release.
REQ-024 Without DIV_5_RST_SYNC_EN, rst_n SHALL be used directly, per REQ-021.

Verification
REQ-025 Clk 20 ns period (first rising edge at 10 ns); rst_n low until 35 ns -> all outputs 0 until the rising edge at 50 ns, where coutpose = 1 and clk_pose = 1; at the falling edge at 60 ns, coutnege = 1 and clk_nege = 1.
REQ-026 Run 1000 ns after release -> coutpose cycles 1,2,3,4,0; every clk_div period after the first is 100 ns with 50 ns high and 50 ns low; clk_div rises coincident with coutpose becoming 0.
REQ-027 Same run -> clk_nege equals clk_pose delayed by 10 ns at every transition; clk_div = clk_pose | clk_nege at all times.
REQ-028 Assert rst_n at 437 ns for 15 ns -> all outputs 0 within the same time step; counting restarts from 0 after release with the sequence of REQ-025.
REQ-029 Force coutpose to 6 for one cycle -> the next rising edge yields 0 and normal sequencing resumes.
REQ-030 With DIV_5_RST_SYNC_EN defined, rst_n released at 35 ns -> coutpose first becomes 1 at 90 ns and coutnege first becomes 1 at 100 ns.
